msg_tx: RTL and testbench

Transmit-side counterpart of the receive buffer. Game logic pushes 8-bit message bytes (letters, status codes) into a small FIFO. The block serializes them onto the wireless/UART link as 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit. It sits between the game FSM and the physical TX pin.

---
 rtl/msg_tx.sv | 146 ++++++++++++++
 tb/tb_msg_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/msg_tx.sv
// msg_tx: byte FIFO feeding an 8N1 serial transmitter.
// Bytes pushed by game logic are queued and sent as start bit, 8 data bits
// LSB first, stop bit. Back-to-back frames leave the line with no idle gap.
//
// Handshake: tx_valid is a push strobe with no back-pressure. A byte offered
// while tx_full is high is dropped and reported by a one-cycle overflow pulse.
module msg_tx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DEPTH        = 4
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       overflow,
  output logic       busy,
  output logic       tx_line
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] cyc;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic          push;
  logic          pop;
  logic          last_cyc;

  assign tx_full  = (count == (AW + 1)'(DEPTH));
  assign tx_empty = (count == '0);
  assign busy     = (state != IDLE) || !tx_empty;

  // Full is judged on the pre-edge count, so a push while full is dropped
  // even if a pop frees a slot on the same edge.
  assign push     = tx_valid && !tx_full;
  assign last_cyc = (cyc == CW'(CLKS_PER_BIT - 1));
  assign pop      = !tx_empty && ((state == IDLE) || ((state == STOP) && last_cyc));

  // FIFO storage; data needs no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_byte;
  end

  // FIFO pointers, occupancy and the overflow pulse.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= tx_valid && tx_full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer with a registered serial output.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      tx_line <= 1'b1;
      cyc     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_line <= 1'b1;
          cyc     <= '0;
          if (pop) begin
            shift   <= mem[rd_ptr];
            state   <= START;
            tx_line <= 1'b0;
          end
        end
        START: begin
          if (last_cyc) begin
            cyc     <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx_line <= shift[0];
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        DATA: begin
          if (last_cyc) begin
            cyc <= '0;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              tx_line <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= {1'b0, shift[7:1]};
              tx_line <= shift[1];
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        STOP: begin
          if (last_cyc) begin
            cyc <= '0;
            if (pop) begin
              shift   <= mem[rd_ptr];
              state   <= START;
              tx_line <= 1'b0;
            end else begin
              state   <= IDLE;
              tx_line <= 1'b1;
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          tx_line <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_tx.sv
// Testbench for msg_tx: drives pushes, decodes the serial line with an
// independent 8N1 receiver and compares received bytes against a queue.
module tb_msg_tx;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_full, tx_empty, overflow, busy, tx_line;

  always #5 clk = ~clk;

  msg_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .Rst      (rst),
    .tx_byte  (tx_byte),
    .tx_valid (tx_valid),
    .tx_full  (tx_full),
    .tx_empty (tx_empty),
    .overflow (overflow),
    .busy     (busy),
    .tx_line  (tx_line)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int         starts[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc_cnt = 0;
  int         frames_seen = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- serial receiver ----------------
  logic       mon_active = 1'b0;
  int         mon_cyc = 0;
  logic [7:0] mon_byte = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx_line == 1'b0) begin
        mon_active = 1'b1;
        mon_cyc    = 0;
        mon_byte   = 8'h00;
        starts.push_back(cyc_cnt);
      end
    end else begin
      mon_cyc++;
      if (mon_cyc == CPB / 2)
        check("start_bit", {31'd0, tx_line}, 32'd0);
      if (mon_cyc >= CPB + CPB / 2 && mon_cyc < 9 * CPB && ((mon_cyc - CPB / 2) % CPB) == 0)
        mon_byte[(mon_cyc - CPB - CPB / 2) / CPB] = tx_line;
      if (mon_cyc == 9 * CPB + CPB / 2) begin
        check("stop_bit", {31'd0, tx_line}, 32'd1);
        frames_seen++;
        if (exp_q.size() == 0) check("frame_unexpected", {24'd0, mon_byte}, 32'hFFFF_FFFF);
        else check("frame_byte", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
      end
      if (mon_cyc == FRAME - 1) mon_active = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Offers one byte on the next edge; returns #1 after that edge.
  task automatic drive(input logic [7:0] b, input bit drop);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_byte  = b;
    if (!drop) exp_q.push_back(b);
    @(posedge clk);
    #1;
  endtask

  task automatic release_valid();
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !busy && !mon_active) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  // Every frame start must follow the previous one by exactly one frame.
  task automatic check_contiguous(input string tag, input int n);
    check({tag, "_frames"}, starts.size(), n);
    for (int i = 1; i < starts.size(); i++)
      check({tag, "_gap"}, starts[i] - starts[i-1], FRAME);
    starts.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_line"},  {31'd0, tx_line},  32'd1);
    check({tag, "_empty"}, {31'd0, tx_empty}, 32'd1);
    check({tag, "_full"},  {31'd0, tx_full},  32'd0);
    check({tag, "_busy"},  {31'd0, busy},     32'd0);
    check({tag, "_ovf"},   {31'd0, overflow}, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int snap;
    logic [7:0] b;

    // 1. reset
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset_idle");
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);

    // 2. single byte with latency and busy timing
    starts.delete();
    drive(8'h41, 1'b0);
    check("single_pre_line", {31'd0, tx_line}, 32'd1);
    check("single_busy", {31'd0, busy}, 32'd1);
    release_valid();
    @(posedge clk);
    #1;
    check("single_start_line", {31'd0, tx_line}, 32'd0);
    repeat (79) @(posedge clk);
    #1;
    check("single_busy_k80", {31'd0, busy}, 32'd1);
    check("single_stop_k80", {31'd0, tx_line}, 32'd1);
    @(posedge clk);
    #1;
    check("single_busy_k81", {31'd0, busy}, 32'd0);
    wait_drain(50);
    check_contiguous("single", 1);

    // 3. back-to-back
    drive(8'h48, 1'b0);
    drive(8'h49, 1'b0);
    drive(8'h21, 1'b0);
    release_valid();
    wait_drain(4 * FRAME);
    check_contiguous("b2b", 3);

    // 4. overflow
    for (int i = 1; i <= 5; i++) begin
      drive(8'(i), 1'b0);
      check("ovf_no_pulse", {31'd0, overflow}, 32'd0);
    end
    check("ovf_full", {31'd0, tx_full}, 32'd1);
    drive(8'h06, 1'b1);
    check("ovf_pulse", {31'd0, overflow}, 32'd1);
    release_valid();
    @(posedge clk);
    #1;
    check("ovf_pulse_end", {31'd0, overflow}, 32'd0);
    wait_drain(6 * FRAME);
    check_contiguous("ovf", 5);

    // 5. reset mid-frame during data bit 3
    drive(8'hA5, 1'b0);
    drive(8'h11, 1'b0);
    drive(8'h22, 1'b0);
    release_valid();
    repeat (34) @(posedge clk);
    #1;
    check("mid_queued", {31'd0, tx_empty}, 32'd0);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_idle("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    starts.delete();
    snap = frames_seen;
    repeat (3 * FRAME) @(posedge clk);
    #1;
    check("mid_no_frames", frames_seen - snap, 32'd0);
    check("mid_no_start", starts.size(), 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);

    // 6. late push during the stop bit
    drive(8'h3C, 1'b0);
    release_valid();
    repeat (75) @(posedge clk);
    drive(8'h5A, 1'b0);
    release_valid();
    wait_drain(3 * FRAME);
    check_contiguous("late", 2);

    // random back-to-back bursts that never exceed capacity
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) begin
        b = 8'($urandom_range(0, 255));
        drive(b, 1'b0);
      end
      release_valid();
      wait_drain(5 * FRAME);
      check_contiguous("rand", 3);
    end

    check("end_queue", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
